// File: rtl/controle_linha_envase_pkg.sv
// Shared definitions for the bottling-line sequencer:
// FSM state encoding and default tuning parameters.
package controle_linha_envase_pkg;

  localparam int W_DEF          = 8;
  localparam int CORK_LOW_DEF   = 5;
  localparam int REFILL_QTY_DEF = 15;
  localparam int MAG_MAX_DEF    = 31;
  localparam int FILL_MAX_DEF   = 64;
  localparam int SEAL_CYC_DEF   = 4;
  localparam int UNID_MAX       = 11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_FILL   = 3'd2,
    S_SEAL   = 3'd3,
    S_REFILL = 3'd4,
    S_ALARM  = 3'd5
  } estado_t;

endpackage

// File: rtl/controle_linha_envase_duzias.sv
// Dozen counter: each incr pulse bumps cont_unid (0..11); the 12th
// rolls it to 0, bumps cont_duzias (wrapping) and pulses duzia_ok.
// Ports: clk, reset (sync, active-high), incr -> cont_unid, cont_duzias, duzia_ok.
module contador_duzias_seq
  import controle_linha_envase_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         incr,
  output logic [3:0]   cont_unid,
  output logic [W-1:0] cont_duzias,
  output logic         duzia_ok
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_unid   <= '0;
      cont_duzias <= '0;
      duzia_ok    <= 1'b0;
    end else begin
      duzia_ok <= 1'b0;
      if (incr) begin
        if (cont_unid == 4'(UNID_MAX)) begin
          cont_unid   <= '0;
          cont_duzias <= cont_duzias + 1'b1;
          duzia_ok    <= 1'b1;
        end else begin
          cont_unid <= cont_unid + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/controle_linha_envase.sv
// Bottling station sequencer: move -> fill -> seal, cork refill, alarms.
// Ports: clk, reset, start, stop, alarm_ack, gar, cheio, load_estoque,
// qnt_estoque in; motor, valvula, ve, done, alarme, estoque, rolha_disp,
// cont_unid, cont_duzias, duzia_ok out (all registered).
module controle_linha_envase
  import controle_linha_envase_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int CORK_LOW   = CORK_LOW_DEF,
  parameter int REFILL_QTY = REFILL_QTY_DEF,
  parameter int MAG_MAX    = MAG_MAX_DEF,
  parameter int FILL_MAX   = FILL_MAX_DEF,
  parameter int SEAL_CYC   = SEAL_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         alarm_ack,
  input  logic         gar,
  input  logic         cheio,
  input  logic         load_estoque,
  input  logic [W-1:0] qnt_estoque,
  output logic         motor,
  output logic         valvula,
  output logic         ve,
  output logic         done,
  output logic         alarme,
  output logic [W-1:0] estoque,
  output logic [W-1:0] rolha_disp,
  output logic [3:0]   cont_unid,
  output logic [W-1:0] cont_duzias,
  output logic         duzia_ok
);

  localparam int FW  = $clog2(FILL_MAX);
  localparam int SCW = $clog2(SEAL_CYC + 1);

  estado_t        state_q, state_d;
  logic           stop_q;
  logic           pend;
  logic [FW-1:0]  fill_cnt;
  logic [SCW-1:0] seal_cnt;
  logic           seal_fim;
  logic [W-1:0]   rd_dec;
  logic [W-1:0]   espaco;
  logic [W-1:0]   n_a;
  logic [W-1:0]   n;
  logic [W-1:0]   n_ref;
  logic [W-1:0]   n_load;
  logic [W:0]     est_sum;
  logic [W-1:0]   est_nxt;

  // A stop pulse counts as pending in the cycle it arrives.
  assign pend     = stop_q | stop;
  assign seal_fim = (state_q == S_SEAL) &&
                    (seal_cnt == SCW'(SEAL_CYC - 1));
  assign rd_dec   = rolha_disp - 1'b1;

  // Refill amount: min(stock, REFILL_QTY, free magazine space).
  always_comb begin
    espaco = W'(MAG_MAX) - rolha_disp;
    n_a    = (estoque < W'(REFILL_QTY)) ? estoque : W'(REFILL_QTY);
    n      = (n_a < espaco) ? n_a : espaco;
    n_ref  = (state_q == S_REFILL) ? n : '0;
    n_load = load_estoque ? qnt_estoque : '0;
    // n never exceeds stock, so the sum cannot underflow.
    est_sum = {1'b0, estoque} - {1'b0, n_ref} + {1'b0, n_load};
    est_nxt = est_sum[W] ? '1 : est_sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rolha_disp != '0)   state_d = S_MOVE;
          else if (estoque != '0) state_d = S_REFILL;
          else                    state_d = S_ALARM;
        end
      end
      S_MOVE: begin
        if (pend)     state_d = S_IDLE;
        else if (gar) state_d = S_FILL;
      end
      S_FILL: begin
        if (cheio) state_d = S_SEAL;
        else if (fill_cnt == FW'(FILL_MAX - 1))
          state_d = S_ALARM;
      end
      S_SEAL: begin
        if (seal_fim) begin
          if (pend)
            state_d = S_IDLE;
          else if (rd_dec <= W'(CORK_LOW) && estoque != '0)
            state_d = S_REFILL;
          else if (rd_dec == '0)
            state_d = S_ALARM;
          else
            state_d = S_MOVE;
        end
      end
      S_REFILL: state_d = pend ? S_IDLE : S_MOVE;
      S_ALARM: begin
        if (alarm_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stop_q     <= 1'b0;
      fill_cnt   <= '0;
      seal_cnt   <= '0;
      motor      <= 1'b0;
      valvula    <= 1'b0;
      ve         <= 1'b0;
      done       <= 1'b0;
      alarme     <= 1'b0;
      estoque    <= '0;
      rolha_disp <= '0;
    end else begin
      state_q <= state_d;
      // Latch is dropped whenever we land in IDLE or ALARM.
      if (state_d == S_IDLE || state_d == S_ALARM)
        stop_q <= 1'b0;
      else
        stop_q <= pend;
      fill_cnt <= (state_q == S_FILL) ? fill_cnt + 1'b1 : '0;
      seal_cnt <= (state_q == S_SEAL && !seal_fim) ?
                  seal_cnt + 1'b1 : '0;
      motor   <= (state_d == S_MOVE);
      valvula <= (state_d == S_FILL);
      ve      <= (state_d == S_SEAL);
      alarme  <= (state_d == S_ALARM);
      done    <= seal_fim;
      estoque <= est_nxt;
      if (state_q == S_REFILL)
        rolha_disp <= rolha_disp + n;
      else if (seal_fim)
        rolha_disp <= rd_dec;
    end
  end

  contador_duzias_seq #(.W(W)) u_duzias (
    .clk         (clk),
    .reset       (reset),
    .incr        (seal_fim),
    .cont_unid   (cont_unid),
    .cont_duzias (cont_duzias),
    .duzia_ok    (duzia_ok)
  );

endmodule

// File: tb/tb_controle_linha_envase.sv
// Directed bench for controle_linha_envase: bottle table plus
// hand-written sequences for refill, timeout, stop and reset cases.
module tb_controle_linha_envase;

  logic       clk = 1'b0;
  logic       reset, start, stop, alarm_ack, gar, cheio, load_estoque;
  logic [7:0] qnt_estoque;
  logic       motor, valvula, ve, done, alarme, duzia_ok;
  logic [7:0] estoque, rolha_disp, cont_duzias;
  logic [3:0] cont_unid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gd;
    int cd;
    int rd;
    int est;
    int unid;
    int duz;
    int dok;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  controle_linha_envase dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .alarm_ack    (alarm_ack),
    .gar          (gar),
    .cheio        (cheio),
    .load_estoque (load_estoque),
    .qnt_estoque  (qnt_estoque),
    .motor        (motor),
    .valvula      (valvula),
    .ve           (ve),
    .done         (done),
    .alarme       (alarme),
    .estoque      (estoque),
    .rolha_disp   (rolha_disp),
    .cont_unid    (cont_unid),
    .cont_duzias  (cont_duzias),
    .duzia_ok     (duzia_ok)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int q);
    load_estoque = 1'b1;
    qnt_estoque  = 8'(q);
    @(negedge clk);
    load_estoque = 1'b0;
    qnt_estoque  = '0;
  endtask

  task automatic wait_motor();
    int i = 0;
    while (!motor && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("motor_on", int'(motor), 1);
  endtask

  // One bottle: gar gd cycles into MOVE, cheio cd cycles into FILL.
  // Returns on the cycle done is seen (or after the budget expires).
  task automatic run_bottle(input int gd, input int cd, input bit stop_fill);
    int i = 0;
    wait_motor();
    repeat (gd) @(negedge clk);
    gar = 1'b1;
    @(negedge clk);
    gar = 1'b0;
    chk("fill_entry", int'(valvula), 1);
    if (stop_fill) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    repeat (cd) @(negedge clk);
    cheio = 1'b1;
    @(negedge clk);
    cheio = 1'b0;
    while (!done && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  initial begin
    int cnt;

    tbl[0]  = '{3, 5, 14, 25,  1, 0, 0};
    tbl[1]  = '{1, 2, 13, 25,  2, 0, 0};
    tbl[2]  = '{0, 0, 12, 25,  3, 0, 0};
    tbl[3]  = '{2, 4, 11, 25,  4, 0, 0};
    tbl[4]  = '{4, 1, 10, 25,  5, 0, 0};
    tbl[5]  = '{1, 3,  9, 25,  6, 0, 0};
    tbl[6]  = '{0, 6,  8, 25,  7, 0, 0};
    tbl[7]  = '{3, 0,  7, 25,  8, 0, 0};
    tbl[8]  = '{2, 2,  6, 25,  9, 0, 0};
    tbl[9]  = '{1, 1,  5, 25, 10, 0, 0};
    tbl[10] = '{0, 3, 19, 10, 11, 0, 0};
    tbl[11] = '{2, 5, 18, 10,  0, 1, 1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; alarm_ack = 1'b0;
    gar = 1'b0; cheio = 1'b0; load_estoque = 1'b0; qnt_estoque = '0;
    @(negedge clk);
    do_reset();
    chk("rst_motor",   int'(motor), 0);
    chk("rst_alarme",  int'(alarme), 0);
    chk("rst_estoque", int'(estoque), 0);
    chk("rst_rolha",   int'(rolha_disp), 0);
    chk("rst_unid",    int'(cont_unid), 0);

    // Empty magazine and stock -> straight to ALARM.
    pulse_start();
    chk("empty_alarm", int'(alarme), 1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("empty_ack", int'(alarme), 0);

    // Load 40, start: refill first.
    load(40);
    chk("load40", int'(estoque), 40);
    pulse_start();
    @(negedge clk);
    chk("refill_rd",  int'(rolha_disp), 15);
    chk("refill_est", int'(estoque), 25);
    chk("move_motor", int'(motor), 1);

    for (int k = 0; k < 12; k++) begin
      run_bottle(tbl[k].gd, tbl[k].cd, 1'b0);
      chk($sformatf("b%0d_rd", k),   int'(rolha_disp), tbl[k].rd);
      chk($sformatf("b%0d_est", k),  int'(estoque), tbl[k].est);
      chk($sformatf("b%0d_unid", k), int'(cont_unid), tbl[k].unid);
      chk($sformatf("b%0d_duz", k),  int'(cont_duzias), tbl[k].duz);
      chk($sformatf("b%0d_dok", k),  int'(duzia_ok), tbl[k].dok);
      @(negedge clk);
      chk($sformatf("b%0d_done1", k), int'(done), 0);
    end

    // Magazine 6, stock 3: seal one -> refill of 3.
    do_reset();
    load(6);
    pulse_start();
    @(negedge clk);
    chk("m6_rd", int'(rolha_disp), 6);
    load(3);
    chk("m6_est", int'(estoque), 3);
    run_bottle(2, 2, 1'b0);
    chk("m6_rd5", int'(rolha_disp), 5);
    @(negedge clk);
    chk("m6_rd8",  int'(rolha_disp), 8);
    chk("m6_est0", int'(estoque), 0);

    // Fill timeout: cheio never arrives.
    wait_motor();
    gar = 1'b1;
    @(negedge clk);
    gar = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (alarme) break;
      if (valvula) cnt++;
      @(negedge clk);
    end
    chk("to_cycles",  cnt, 64);
    chk("to_alarme",  int'(alarme), 1);
    chk("to_valvula", int'(valvula), 0);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("to_ack", int'(alarme), 0);
    chk("to_idle_motor", int'(motor), 0);

    // Stop during FILL: bottle completes, then IDLE.
    pulse_start();
    run_bottle(1, 2, 1'b1);
    chk("sf_rd", int'(rolha_disp), 7);
    chk("sf_motor0", int'(motor), 0);
    repeat (3) @(negedge clk);
    chk("sf_idle", int'(motor), 0);

    // Stop during MOVE: IDLE on the next cycle.
    pulse_start();
    wait_motor();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("sm_motor0", int'(motor), 0);
    repeat (2) @(negedge clk);
    chk("sm_idle", int'(motor), 0);

    // Stock saturation.
    do_reset();
    load(10);
    load(250);
    chk("sat", int'(estoque), 255);

    // Reset in the middle of SEAL.
    pulse_start();
    wait_motor();
    gar = 1'b1;
    @(negedge clk);
    gar = 1'b0;
    cheio = 1'b1;
    @(negedge clk);
    cheio = 1'b0;
    @(negedge clk);
    chk("seal_ve", int'(ve), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_ve",      int'(ve), 0);
    chk("rs_done",    int'(done), 0);
    chk("rs_estoque", int'(estoque), 0);
    chk("rs_rolha",   int'(rolha_disp), 0);
    chk("rs_unid",    int'(cont_unid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs_idle", int'(motor), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
